uart_tx_buf: RTL and testbench

UART transmitter that serializes one byte per frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), at a fixed baud divisor. It includes a one-entry holding register so firmware/logic can queue the next byte while the current frame is still shifting. Consecutive frames are then sent with no idle gap. It pairs with the team's UART receiver on the remote/command link.

---
 rtl/uart_tx_buf.sv | 99 +++++++++
 tb/tb_uart_tx_buf.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - UART transmitter (8N1) with a one-entry holding register
// Frames chain back-to-back when a byte is waiting at the end of the current stop bit.
module uart_tx_buf #(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done,
   output logic       busy,
   output logic       hold_full
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

   typedef enum logic {IDLE = 1'b0, TRANSMIT = 1'b1} state_t;

   state_t          state;
   state_t          next_state;
   logic [9:0]      shift_reg;
   logic [CW-1:0]   baud_cnt;
   logic [3:0]      bit_cnt;
   logic [7:0]      hold_reg;
   logic            shift;
   logic            frame_end;
   logic            load_new;
   logic            load_hold;
   logic            capture;
   logic            set_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // A trmt coinciding with the last shift is a chain load when nothing is held,
   // otherwise it refills the holding register that is being emptied this edge.
   always_comb begin
      shift      = (state == TRANSMIT) && (baud_cnt == BAUD_LAST);
      frame_end  = shift && (bit_cnt == 4'd9);
      load_hold  = frame_end && hold_full;
      load_new   = trmt && ((state == IDLE) || (frame_end && !hold_full));
      capture    = trmt && (state == TRANSMIT) && (frame_end == hold_full);
      set_done   = frame_end && !hold_full && !trmt;
      next_state = state;
      if (state == IDLE) begin
         if (trmt) next_state = TRANSMIT;
      end else begin
         if (set_done) next_state = IDLE;
      end
   end

   always_comb begin
      busy = (state == TRANSMIT);
      TX   = shift_reg[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         hold_reg  <= '0;
         hold_full <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         if (load_new)
            shift_reg <= {1'b1, tx_data, 1'b0};
         else if (load_hold)
            shift_reg <= {1'b1, hold_reg, 1'b0};
         else if (shift)
            shift_reg <= {1'b1, shift_reg[9:1]};

         if (load_new || load_hold) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end else if (shift) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
         end else if (state == TRANSMIT) begin
            baud_cnt <= baud_cnt + CW'(1);
         end

         if (capture) begin
            hold_reg  <= tx_data;
            hold_full <= 1'b1;
         end else if (load_hold) begin
            hold_full <= 1'b0;
         end

         if (set_done)  tx_done <= 1'b1;
         else if (trmt) tx_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - bench for uart_tx_buf against a frame-timing reference model
module tb_uart_tx_buf;

   localparam int B     = 16;
   localparam int FRAME = 10 * B;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       trmt    = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       TX;
   logic       tx_done;
   logic       busy;
   logic       hold_full;

   uart_tx_buf #(.BAUD_DIV(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trmt      (trmt),
      .tx_data   (tx_data),
      .TX        (TX),
      .tx_done   (tx_done),
      .busy      (busy),
      .hold_full (hold_full)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: each frame is a start time plus a byte; the line value is derived
   // from elapsed cycles divided by the bit period.
   int         cyc;
   bit         m_active;
   bit         m_hold_v;
   bit         m_done;
   int         m_start;
   int         m_end;
   logic [7:0] m_byte;
   logic [7:0] m_hold_b;

   task automatic chk(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic m_reset();
      cyc      = 0;
      m_active = 1'b0;
      m_hold_v = 1'b0;
      m_done   = 1'b0;
      m_start  = 0;
      m_end    = 0;
      m_byte   = 8'h00;
      m_hold_b = 8'h00;
   endtask

   task automatic m_start_frame(input logic [7:0] d);
      m_active = 1'b1;
      m_start  = cyc;
      m_end    = cyc + FRAME;
      m_byte   = d;
   endtask

   task automatic m_edge(input logic t, input logic [7:0] d);
      cyc++;
      if (m_active && cyc == m_end) begin
         if (m_hold_v) begin
            m_start_frame(m_hold_b);
            m_hold_v = 1'b0;
         end else begin
            m_active = 1'b0;
            if (!t) m_done = 1'b1;
         end
      end
      if (t) begin
         if (!m_active) m_start_frame(d);
         else if (!m_hold_v) begin
            m_hold_v = 1'b1;
            m_hold_b = d;
         end
         m_done = 1'b0;
      end
   endtask

   function automatic logic m_tx();
      logic [9:0] fr;
      if (!m_active) return 1'b1;
      fr = {1'b1, m_byte, 1'b0};
      return fr[(cyc - m_start) / B];
   endfunction

   task automatic check_all();
      chk("TX", TX, m_tx());
      chk("busy", busy, m_active);
      chk("hold_full", hold_full, m_hold_v);
      chk("tx_done", tx_done, m_done);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_TX"}, TX, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_hold_full"}, hold_full, 1'b0);
      chk({tag, "_tx_done"}, tx_done, 1'b0);
   endtask

   task automatic cycle(input logic t, input logic [7:0] d);
      trmt    = t;
      tx_data = d;
      @(posedge clk);
      m_edge(t, d);
      #1;
      trmt    = 1'b0;
      tx_data = 8'($urandom);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
   endtask

   initial begin
      m_reset();
      rst_n = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         check_reset("rst");
      end
      rst_n = 1'b1;
      m_reset();
      idle(300);

      // single byte, full frame and tx_done edge
      cycle(1'b1, 8'hA5);
      idle(FRAME + 10);

      // back-to-back through the holding register, second trmt 50 cycles later
      cycle(1'b1, 8'h12);
      idle(49);
      cycle(1'b1, 8'h34);
      idle(2 * FRAME + 10);

      // overflow: third byte dropped
      cycle(1'b1, 8'h12);
      idle(20);
      cycle(1'b1, 8'h34);
      idle(20);
      cycle(1'b1, 8'h56);
      idle(2 * FRAME + 10);

      // trmt on the final shift with nothing held: chain load
      cycle(1'b1, 8'h3C);
      idle(FRAME - 1);
      cycle(1'b1, 8'hC3);
      idle(FRAME + 10);

      // trmt on the final shift with a byte held: hold refilled
      cycle(1'b1, 8'h11);
      idle(5);
      cycle(1'b1, 8'h22);
      idle(FRAME - 7);
      cycle(1'b1, 8'h33);
      idle(3 * FRAME + 10);

      // random traffic
      for (int i = 0; i < 3000; i++)
         cycle(logic'($urandom_range(0, 39) == 0), 8'($urandom));
      idle(2 * FRAME + 10);

      // asynchronous reset during data bit 3 with a byte held
      cycle(1'b1, 8'h5A);
      idle(3);
      cycle(1'b1, 8'h77);
      idle(4 * B - 2);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      repeat (3) begin
         @(posedge clk);
         #1;
         check_reset("rst_hold");
      end
      rst_n = 1'b1;
      m_reset();
      cycle(1'b1, 8'h81);
      idle(FRAME + 20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
